// File: rtl/fpu_mantissa_normalizer.sv
// Iterative left-normalizer for extended-precision mantissas: whole zero bytes
// are stripped in SCAN, then one sub-byte shift in FINE, clamped by the exponent.
module fpu_mantissa_normalizer #(
  parameter int MANT_W = 64,
  parameter int EXP_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_underflow
);

  typedef enum logic [1:0] {IDLE, SCAN, FINE, DONE} state_t;

  state_t            state;
  logic [MANT_W-1:0] mant_q;
  logic [EXP_W-1:0]  exp_q;
  logic              zero_q, uf_q;

  logic [7:0] top;
  logic [3:0] lz, sh;

  assign top = mant_q[MANT_W-1 -: 8];

  // Highest set bit wins; an all-zero byte reports 8.
  always_comb begin
    lz = 4'd8;
    for (int i = 0; i < 8; i++)
      if (top[i]) lz = 4'(7 - i);
  end

  // The exponent may not drop below zero: shift only as far as it allows.
  always_comb begin
    sh = lz;
    if (exp_q < EXP_W'(lz)) sh = exp_q[3:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mant_q <= '0;
      exp_q  <= '0;
      zero_q <= 1'b0;
      uf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mant_q <= in_mant;
          exp_q  <= in_exp;
          zero_q <= 1'b0;
          uf_q   <= 1'b0;
          state  <= SCAN;
        end
        SCAN: begin
          if (mant_q == '0) begin
            exp_q  <= '0;
            zero_q <= 1'b1;
            state  <= DONE;
          end else if (top == 8'd0 && exp_q >= EXP_W'(8)) begin
            mant_q <= mant_q << 8;
            exp_q  <= exp_q - EXP_W'(8);
          end else begin
            state <= FINE;
          end
        end
        FINE: begin
          mant_q <= mant_q << sh;
          exp_q  <= exp_q - EXP_W'(sh);
          uf_q   <= (sh < lz);
          state  <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign out_mant      = mant_q;
  assign out_exp       = exp_q;
  assign out_zero      = zero_q;
  assign out_underflow = uf_q;

endmodule

// File: tb/tb_fpu_mantissa_normalizer.sv
// Scoreboard bench for fpu_mantissa_normalizer: directed corner cases plus
// random operands checked against a plain leading-zero/min reference model.
module tb_fpu_mantissa_normalizer;

  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [63:0] in_mant = '0;
  logic [14:0] in_exp = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [63:0] out_mant;
  logic [14:0] out_exp;
  logic        out_zero, out_underflow;

  fpu_mantissa_normalizer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_exp(out_exp), .out_zero(out_zero), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] m;
    logic [14:0] e;
    logic        z;
    logic        u;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   tq[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;
  logic hold5 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: shift by the full leading-zero count, limited by the exponent.
  function automatic exp_t model(input logic [63:0] m, input logic [14:0] e);
    exp_t r;
    int n, sh, k;
    if (m == 64'd0) begin
      r.m = '0; r.e = '0; r.z = 1; r.u = 0; r.lat = 8'd2;
      return r;
    end
    n = 0;
    while (n < 64 && m[63-n] == 1'b0) n++;
    sh = (n < int'(e)) ? n : int'(e);
    k  = ((n / 8) < (int'(e) / 8)) ? n / 8 : int'(e) / 8;
    r.m = m << sh;
    r.e = e - 15'(sh);
    r.z = 0;
    r.u = (sh < n);
    r.lat = 8'(3 + k);
    return r;
  endfunction

  // Monitor: samples on the falling edge, away from state changes.
  logic        prev_ov = 0;
  logic [63:0] hm;
  logic [14:0] he;
  logic        hz, hu;
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) tq.push_back(cyc);
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0 || tq.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          chk("latency", 64'(cyc - tq[0]), 64'(sb[0].lat));
        end
        hm = out_mant; he = out_exp; hz = out_zero; hu = out_underflow;
      end else if (out_valid) begin
        chk("hold_mant", out_mant, hm);
        chk("hold_exp", 64'(out_exp), 64'(he));
        chk("hold_flags", {62'd0, out_zero, out_underflow}, {62'd0, hz, hu});
        chk("busy_in_ready", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        if (tq.size() > 0) void'(tq.pop_front());
        chk("mant", out_mant, x.m);
        chk("exp", 64'(out_exp), 64'(x.e));
        chk("zero", 64'(out_zero), 64'(x.z));
        chk("underflow", 64'(out_underflow), 64'(x.u));
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 0;
    end
  end

  // Backpressure: random, or exactly five low cycles at the start of DONE.
  int held = 0;
  always @(posedge clk) begin
    #1;
    if (hold5) begin
      if (out_valid && held < 5) begin out_ready = 0; held++; end
      else out_ready = 1;
    end else begin
      held = 0;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [63:0] m, input logic [14:0] e);
    int t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    in_valid = 1; in_mant = m; in_exp = e;
    sb.push_back(model(m, e));
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 2000) begin @(posedge clk); #1; t++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mant", out_mant, 64'd0);
    chk("rst_exp", 64'(out_exp), 64'd0);
    chk("rst_flags", {62'd0, out_zero, out_underflow}, 64'd0);

    issue(64'h8000_0000_0000_0001, 15'h3FFF); drain();
    issue(64'h0000_0000_0000_0001, 15'd100);  drain();
    issue(64'h0, 15'h1234);                   drain();
    issue(64'h0000_0100_0000_0000, 15'd3);    drain();

    // Held result under five cycles of backpressure, then back to IDLE.
    hold5 = 1;
    issue(64'h00F0_0000_0000_0000, 15'd500);
    drain();
    @(negedge clk);
    chk("post_done_in_ready", 64'(in_ready), 64'd1);
    chk("post_done_out_valid", 64'(out_valid), 64'd0);
    hold5 = 0;

    // Abort mid-SCAN; the queued expectation is discarded with it.
    issue(64'h0000_0000_0000_0001, 15'd100);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sb.delete(); tq.delete();
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    repeat (15) @(posedge clk);

    for (int i = 0; i < 200; i++) begin
      int n;
      logic [63:0] m;
      logic [14:0] e;
      n = $urandom_range(0, 64);
      m = {$urandom, $urandom};
      m = (n == 64) ? 64'd0 : ((m | 64'h8000_0000_0000_0000) >> n);
      case ($urandom_range(0, 3))
        0: e = 15'($urandom_range(0, 20));
        1: e = 15'($urandom);
        2: e = 15'($urandom_range(0, 70));
        default: e = 15'h3FFF;
      endcase
      issue(m, e);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
